db_bus_arbiter: RTL
===================

// Module: db_bus_arbiter
// PURPOSE
//   Round-robin arbiter sharing one data-bus port among NUM_REQ core pipelines (DbLoad/DbStore traffic).
//   Accepts one request at a time, drives a single valid/ready bus transaction, returns read data and a
//   one-cycle ack to the winner. Bounds every transaction with a timeout so a dead target cannot hang the cores.
// PARAMETERS
//   NUM_REQ   4    number of requesters (>=2)
//   ADDR_W    16   bus address width
//   DATA_W    16   bus data width
//   TIMEOUT   64   max cycles oBusValid is held without iBusReady before abort (>=2)
// PORTS
//   iclk        in   1                 clock, all state on rising edge
//   irst_n      in   1                 asynchronous active-low reset
//   iReq        in   NUM_REQ           per-requester request level; hold until oAck
//   iWrite      in   NUM_REQ           1=store, 0=load; valid with iReq
//   iAddr       in   NUM_REQ*ADDR_W    requester i at [i*ADDR_W +: ADDR_W]
//   iWData      in   NUM_REQ*DATA_W    requester i at [i*DATA_W +: DATA_W]
//   oGnt        out  NUM_REQ           one-hot owner of the bus, 0 when idle
//   oAck        out  NUM_REQ           one-cycle completion pulse to owner
//   oErr        out  1                 high with oAck when transaction timed out
//   oRData      out  DATA_W            load data, valid only while oAck!=0
//   oBusValid   out  1                 transaction valid on bus
//   oBusWrite   out  1                 transaction is a write
//   oBusAddr    out  ADDR_W            transaction address
//   oBusWData   out  DATA_W            write data
//   iBusReady   in   1                 target accepts/completes transaction this cycle
//   iBusRData   in   DATA_W            read data, sampled when oBusValid & iBusReady
// BEHAVIOUR
//   Reset: state IDLE, rr_ptr=0, timeout count=0; all outputs 0. Asserting irst_n low mid-transaction
//     clears oBusValid/oGnt immediately; the transaction is lost, no oAck is issued.
//   States: IDLE -> BUSY -> ACK -> IDLE. All outputs registered.
//   IDLE: if |iReq, winner = first i with iReq[i] searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     Next edge: latch iWrite/iAddr/iWData of winner into oBusWrite/oBusAddr/oBusWData, oBusValid=1,
//     oGnt=one-hot(winner), count=0, -> BUSY. No request: stay IDLE, outputs unchanged (0).
//   BUSY: bus signals held stable. iBusReady=1 at an edge: oBusValid<=0, oRData<=iBusRData (loads;
//     writes give oRData=0), oAck[winner]<=1, oErr<=0, -> ACK.
//     Else count++; at count==TIMEOUT-1 without ready: oBusValid<=0, oRData<=0, oAck[winner]<=1,
//     oErr<=1, -> ACK.
//   ACK: oAck/oErr/oRData valid for exactly this cycle; oGnt still held. Next edge: oAck, oErr, oGnt,
//     oRData <=0, rr_ptr <= (winner+1) mod NUM_REQ, -> IDLE.
//   Requester contract: deassert iReq at the edge ending the ACK cycle; arbiter never samples iReq
//     outside IDLE, so iReq changes during BUSY/ACK have no effect.
//   Latency: iReq seen in IDLE at edge t -> oBusValid high from t; iBusReady at edge t+k ->
//     oAck high for cycle t+k..t+k+1; earliest next grant edge t+k+2. Minimum 3 cycles/transaction.
//   Fairness: a continuously requesting core waits at most NUM_REQ-1 transactions.
//   rr_ptr wraps NUM_REQ-1 -> 0. Simultaneous requests resolved purely by rr_ptr order.
//   iBusReady while not BUSY is ignored.
// TESTING
//   1 Reset: irst_n=0 mid-BUSY (oBusValid=1) -> oBusValid,oGnt,oAck,oErr=0 at once; no ack after release.
//   2 Single load: iReq=0001, iAddr[0]=16'h0040, iBusReady 2 cycles later, iBusRData=16'hBEEF ->
//     oGnt=0001, oBusAddr=0040, oBusWrite=0; oAck=0001, oRData=BEEF for exactly 1 cycle.
//   3 Round robin: iReq=1111 held, 1-cycle ready -> grant order 0,1,2,3,0; each grant 3 cycles apart.
//   4 Wrap/skip: rr_ptr=3, iReq=0110 -> grant requester 1, then 2; rr_ptr becomes 3 (wraps properly).
//   5 Store: iReq=0100, iWrite[2]=1, iWData[2]=16'h1234, ready on 1st cycle -> oBusWrite=1,
//     oBusWData=1234, oAck=0100, oRData=0, oErr=0.
//   6 Timeout: iReq=0010, iBusReady stuck 0 -> oBusValid high 63 cycles, then oAck=0010, oErr=1, oRData=0;
//     next request is arbitrated normally.

Source files
------------

// File: rtl/db_bus_arbiter.sv
// Round-robin arbiter that shares one valid/ready data-bus port among NUM_REQ requesters.
// One transaction at a time; a stuck target is aborted after TIMEOUT-1 cycles and flagged with oErr.
module db_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                        iclk,
  input  logic                        irst_n,
  input  logic [NUM_REQ-1:0]          iReq,
  input  logic [NUM_REQ-1:0]          iWrite,
  input  logic [NUM_REQ*ADDR_W-1:0]   iAddr,
  input  logic [NUM_REQ*DATA_W-1:0]   iWData,
  output logic [NUM_REQ-1:0]          oGnt,
  output logic [NUM_REQ-1:0]          oAck,
  output logic                        oErr,
  output logic [DATA_W-1:0]           oRData,
  output logic                        oBusValid,
  output logic                        oBusWrite,
  output logic [ADDR_W-1:0]           oBusAddr,
  output logic [DATA_W-1:0]           oBusWData,
  input  logic                        iBusReady,
  input  logic [DATA_W-1:0]           iBusRData
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ACK} state_t;

  state_t              r_state, w_state;
  logic [PTR_W-1:0]    r_ptr, w_ptr;
  logic [PTR_W-1:0]    r_win, w_win;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt;
  logic [NUM_REQ-1:0]  r_ack, w_ack;
  logic                r_err, w_err;
  logic [DATA_W-1:0]   r_rdata, w_rdata;
  logic                r_bus_valid, w_bus_valid;
  logic                r_bus_write, w_bus_write;
  logic [ADDR_W-1:0]   r_bus_addr, w_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata, w_bus_wdata;

  logic                w_found;
  logic [PTR_W-1:0]    w_pick;
  logic                w_pick_write;
  logic [ADDR_W-1:0]   w_pick_addr;
  logic [DATA_W-1:0]   w_pick_wdata;

  // Search starts at r_ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    int idx;
    w_found      = 1'b0;
    w_pick       = '0;
    w_pick_write = 1'b0;
    w_pick_addr  = '0;
    w_pick_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && iReq[PTR_W'(idx)]) begin
        w_found      = 1'b1;
        w_pick       = PTR_W'(idx);
        w_pick_write = iWrite[PTR_W'(idx)];
        w_pick_addr  = iAddr[idx*ADDR_W +: ADDR_W];
        w_pick_wdata = iWData[idx*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_win       = r_win;
    w_cnt       = r_cnt;
    w_gnt       = r_gnt;
    w_ack       = r_ack;
    w_err       = r_err;
    w_rdata     = r_rdata;
    w_bus_valid = r_bus_valid;
    w_bus_write = r_bus_write;
    w_bus_addr  = r_bus_addr;
    w_bus_wdata = r_bus_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_bus_valid = 1'b1;
          w_bus_write = w_pick_write;
          w_bus_addr  = w_pick_addr;
          w_bus_wdata = w_pick_wdata;
          w_gnt       = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
          w_win       = w_pick;
          w_cnt       = '0;
          w_state     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (iBusReady || (r_cnt == CNT_W'(TIMEOUT-2))) begin
          w_bus_valid = 1'b0;
          w_bus_write = 1'b0;
          w_bus_addr  = '0;
          w_bus_wdata = '0;
          w_ack       = r_gnt;
          w_err       = !iBusReady;
          w_rdata     = (iBusReady && !r_bus_write) ? iBusRData : '0;
          w_state     = ST_ACK;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_ACK: begin
        w_ack   = '0;
        w_err   = 1'b0;
        w_gnt   = '0;
        w_rdata = '0;
        w_ptr   = (r_win == PTR_W'(NUM_REQ-1)) ? '0 : r_win + 1'b1;
        w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_bus_valid <= 1'b0;
      r_bus_write <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_state     <= w_state;
      r_ptr       <= w_ptr;
      r_win       <= w_win;
      r_cnt       <= w_cnt;
      r_gnt       <= w_gnt;
      r_ack       <= w_ack;
      r_err       <= w_err;
      r_rdata     <= w_rdata;
      r_bus_valid <= w_bus_valid;
      r_bus_write <= w_bus_write;
      r_bus_addr  <= w_bus_addr;
      r_bus_wdata <= w_bus_wdata;
    end
  end

  assign oGnt      = r_gnt;
  assign oAck      = r_ack;
  assign oErr      = r_err;
  assign oRData    = r_rdata;
  assign oBusValid = r_bus_valid;
  assign oBusWrite = r_bus_write;
  assign oBusAddr  = r_bus_addr;
  assign oBusWData = r_bus_wdata;

endmodule
